// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity-mode codes and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // XOR of the low nbits of c, inverted for odd parity.
    function automatic logic parity_of(input logic [7:0] c, input logic [3:0] nbits,
                                       input logic odd);
        logic p;
        p = odd;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < 32'(nbits)) begin
                p = p ^ c[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 and flags the terminal count; restart_i parks the count at 0.
module uart_baud_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || (cnt_q == CNT_W'(DIV - 1))) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // tick_q mirrors "cnt_q is at terminal count" so the flag stays registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= (DIV == 1);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_W'(DIV - 1));
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-character UART transmitter: sends len characters as back-to-back frames.
// Parity generation is compiled in only when UART_TX_PARITY_EN is defined.
module uart_frame_tx #(
    parameter int unsigned CHAR_NR   = 8,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHAR_NR*8-1:0]         char_array_i,
    input  logic [$clog2(CHAR_NR+1)-1:0] len_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [1:0]                   parity_i,
    input  logic                         two_stop_i,
    input  logic                         clr_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         txd_o
);

    import uart_pkg::*;

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned LEN_W    = $clog2(CHAR_NR + 1);
    localparam int unsigned IDX_W    = (CHAR_NR > 1) ? $clog2(CHAR_NR) : 1;
    localparam int unsigned MSG_W    = CHAR_NR * 8;

    uart_tx_state_t   state_q;
    logic [MSG_W-1:0] chars_q;
    logic [LEN_W-1:0] len_q;
    logic             par_en_q;
    logic             par_odd_q;
    logic             two_stop_q;
    logic [IDX_W-1:0] char_idx_q;
    logic [2:0]       bit_idx_q;
    logic             stop_idx_q;
    logic             txd_q;
    logic             busy_q;
    logic             done_q;

    logic             tick;
    logic             restart;
    logic             ready_c;
    logic [LEN_W-1:0] len_clamp_c;
    logic [7:0]       cur_char_c;
    logic             last_char_c;
    logic             last_bit_c;
    logic             par_bit_c;
    logic             par_sel_en_c;
    logic             par_sel_odd_c;

`ifdef UART_TX_PARITY_EN
    assign par_sel_en_c  = (parity_i == PAR_EVEN) || (parity_i == PAR_ODD);
    assign par_sel_odd_c = (parity_i == PAR_ODD);
`else
    logic unused_parity;
    assign unused_parity = ^parity_i;
    assign par_sel_en_c  = 1'b0;
    assign par_sel_odd_c = 1'b0;
`endif

    assign ready_c     = (state_q == IDLE) && !clr_i;
    assign len_clamp_c = (32'(len_i) > CHAR_NR) ? LEN_W'(CHAR_NR) : len_i;
    assign cur_char_c  = chars_q[{char_idx_q, 3'b000} +: 8];
    assign last_char_c = ((LEN_W'(char_idx_q) + LEN_W'(1)) == len_q);
    assign last_bit_c  = (bit_idx_q == 3'(DATA_BITS - 1));
    assign par_bit_c   = parity_of(cur_char_c, 4'(DATA_BITS), par_odd_q);

    // Bit timing restarts on every acceptance and on abort.
    assign restart = (state_q == IDLE) || clr_i;

    uart_baud_gen #(
        .DIV(BAUD_DIV)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(restart),
        .tick_o   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            chars_q    <= '0;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            char_idx_q <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr_i) begin
                state_q    <= IDLE;
                char_idx_q <= '0;
                bit_idx_q  <= '0;
                stop_idx_q <= 1'b0;
                txd_q      <= 1'b1;
                busy_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (valid_i) begin
                            chars_q    <= char_array_i;
                            len_q      <= len_clamp_c;
                            par_en_q   <= par_sel_en_c;
                            par_odd_q  <= par_sel_odd_c;
                            two_stop_q <= two_stop_i;
                            char_idx_q <= '0;
                            bit_idx_q  <= '0;
                            stop_idx_q <= 1'b0;
                            if (len_clamp_c == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= START;
                                txd_q   <= 1'b0;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    START: begin
                        if (tick) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                            txd_q     <= cur_char_c[0];
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            if (!last_bit_c) begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                                txd_q     <= cur_char_c[bit_idx_q + 3'd1];
                            end else if (par_en_q) begin
                                state_q <= PARITY;
                                txd_q   <= par_bit_c;
                            end else begin
                                state_q    <= STOP;
                                stop_idx_q <= 1'b0;
                                txd_q      <= 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        if (tick) begin
                            state_q    <= STOP;
                            stop_idx_q <= 1'b0;
                            txd_q      <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            if (two_stop_q && !stop_idx_q) begin
                                stop_idx_q <= 1'b1;
                            end else if (last_char_c) begin
                                state_q    <= IDLE;
                                char_idx_q <= '0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                            end else begin
                                // Next character's start bit follows the stop bit directly.
                                state_q    <= START;
                                char_idx_q <= char_idx_q + IDX_W'(1);
                                stop_idx_q <= 1'b0;
                                txd_q      <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        txd_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ready_o = ready_c;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign txd_o   = txd_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: expected per-cycle line/busy/done waveform is queued at
// acceptance and compared every cycle by an independent monitor (8-bit and 7-bit instances).
module tb_uart_frame_tx;

    localparam int unsigned CF = 1_000_000;
    localparam int unsigned BR = 100_000;
    localparam int BD = 10;
    localparam int CN = 8;

    typedef struct packed {
        logic txd;
        logic busy;
        logic done;
    } exp_t;

    localparam exp_t IDLE_E = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] chars_a, chars_b;
    logic [3:0]  len_a, len_b;
    logic        valid_a, valid_b;
    logic [1:0]  par_a, par_b;
    logic        two_a, two_b;
    logic        clr_a, clr_b;
    logic        ready_a, ready_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;
    logic        txd_a, txd_b;

    int checks = 0;
    int errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    uart_frame_tx #(.CHAR_NR(CN), .DATA_BITS(8), .CLK_FREQ(CF), .BAUD_RATE(BR)) dut_a (
        .clk(clk), .rst_n(rst_n), .char_array_i(chars_a), .len_i(len_a), .valid_i(valid_a),
        .ready_o(ready_a), .parity_i(par_a), .two_stop_i(two_a), .clr_i(clr_a),
        .busy_o(busy_a), .done_o(done_a), .txd_o(txd_a));

    uart_frame_tx #(.CHAR_NR(CN), .DATA_BITS(7), .CLK_FREQ(CF), .BAUD_RATE(BR)) dut_b (
        .clk(clk), .rst_n(rst_n), .char_array_i(chars_b), .len_i(len_b), .valid_i(valid_b),
        .ready_o(ready_b), .parity_i(par_b), .two_stop_i(two_b), .clr_i(clr_b),
        .busy_o(busy_b), .done_o(done_b), .txd_o(txd_b));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int which, input exp_t e);
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
    endtask

    // Reference model: expand a message into line levels, BD clocks per bit.
    task automatic push_msg(input int which, input int dbits, input logic [63:0] c, input int len,
                            input logic [1:0] par, input logic two);
        int   n;
        int   ones;
        logic par_on;
        logic bits[$];
        n = (len > CN) ? CN : len;
        par_on = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_on = (par == 2'd1) || (par == 2'd2);
`endif
        for (int k = 0; k < n; k++) begin
            bits.push_back(1'b0);
            ones = 0;
            for (int b = 0; b < dbits; b++) begin
                bits.push_back(c[k*8+b]);
                ones += int'(c[k*8+b]);
            end
            if (par_on) bits.push_back(ones[0] ^ (par == 2'd2));
            bits.push_back(1'b1);
            if (two) bits.push_back(1'b1);
        end
        foreach (bits[i]) begin
            for (int r = 0; r < BD; r++) push_exp(which, {bits[i], 1'b1, 1'b0});
        end
        push_exp(which, 3'b101);
    endtask

    task automatic send(input int which, input logic [63:0] c, input logic [3:0] l,
                        input logic [1:0] p, input logic t);
        int waited;
        waited = 0;
        @(negedge clk);
        while (((which == 0) ? !ready_a : !ready_b) && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait_timeout", 32'(waited >= 5000), 32'd0);
        if (which == 0) begin
            chars_a = c; len_a = l; par_a = p; two_a = t; valid_a = 1'b1;
        end else begin
            chars_b = c; len_b = l; par_b = p; two_b = t; valid_b = 1'b1;
        end
        @(posedge clk);
        push_msg(which, (which == 0) ? 8 : 7, c, int'(l), p, t);
        #1;
        // Scramble inputs after acceptance; the message in flight must not change.
        if (which == 0) begin
            valid_a = 1'b0; chars_a = {$urandom, $urandom}; len_a = 4'($urandom);
            par_a = 2'($urandom); two_a = 1'($urandom);
        end else begin
            valid_b = 1'b0; chars_b = {$urandom, $urandom}; len_b = 4'($urandom);
            par_b = 2'($urandom); two_b = 1'($urandom);
        end
    endtask

    task automatic wait_done(input int which, input int exp_cyc, input string name);
        int c;
        c = 1;
        @(negedge clk);
        while (!((which == 0) ? done_a : done_b) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk(name, 32'(c), 32'(exp_cyc));
    endtask

    // Monitor: one comparison per cycle and instance against the scoreboard queues.
    always @(negedge clk) begin
        exp_t ea, eb;
        ea = (q_a.size() > 0) ? q_a.pop_front() : IDLE_E;
        eb = (q_b.size() > 0) ? q_b.pop_front() : IDLE_E;
        checks += 2;
        if ({txd_a, busy_a, done_a} !== ea) begin
            errors++;
            $display("FAIL line_a t=%0t: got txd/busy/done=%b expected %b", $time,
                     {txd_a, busy_a, done_a}, ea);
        end
        if ({txd_b, busy_b, done_b} !== eb) begin
            errors++;
            $display("FAIL line_b t=%0t: got txd/busy/done=%b expected %b", $time,
                     {txd_b, busy_b, done_b}, eb);
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int p33, p37, w;
        rst_n = 1'b0;
        chars_a = '0; len_a = '0; valid_a = 1'b0; par_a = '0; two_a = 1'b0; clr_a = 1'b0;
        chars_b = '0; len_b = '0; valid_b = 1'b0; par_b = '0; two_b = 1'b0; clr_b = 1'b0;
`ifdef UART_TX_PARITY_EN
        p33 = 241; p37 = 101;
`else
        p33 = 221; p37 = 91;
`endif
        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd_a), 32'd1);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_done", 32'(done_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(ready_a), 32'd1);

        send(0, 64'h55, 4'd1, 2'd0, 1'b0);
        wait_done(0, 101, "done_cycle_0x55");

        send(0, 64'h0301, 4'd2, 2'd1, 1'b1);
        wait_done(0, p33, "done_cycle_even_two_stop");

        send(0, {$urandom, $urandom}, 4'd0, 2'd1, 1'b1);
        wait_done(0, 1, "done_cycle_len0");
        chk("len0_busy", 32'(busy_a), 32'd0);
        chk("len0_txd", 32'(txd_a), 32'd1);

        send(0, {$urandom, $urandom}, 4'd12, 2'd0, 1'b0);
        wait_done(0, 801, "done_cycle_len_clamped");

        // New request while busy must be ignored.
        send(0, {$urandom, $urandom}, 4'd3, 2'd0, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        chars_a = {$urandom, $urandom}; len_a = 4'd1; valid_a = 1'b1;
        @(negedge clk);
        chk("busy_ready_low", 32'(ready_a), 32'd0);
        @(posedge clk);
        #1 valid_a = 1'b0;

        // Abort during the data bits of the third character.
        send(0, {$urandom, $urandom}, 4'd8, 2'd0, 1'b0);
        repeat (230) @(posedge clk);
        #1 clr_a = 1'b1;
        @(negedge clk);
        chk("clr_ready_low", 32'(ready_a), 32'd0);
        @(posedge clk);
        q_a.delete();
        #1 clr_a = 1'b0;
        @(negedge clk);
        chk("clr_txd", 32'(txd_a), 32'd1);
        chk("clr_busy", 32'(busy_a), 32'd0);
        chk("clr_done", 32'(done_a), 32'd0);
        chk("clr_ready", 32'(ready_a), 32'd1);
        repeat (20) @(negedge clk);

        // Reset mid-frame abandons the message.
        send(0, {$urandom, $urandom}, 4'd4, 2'($urandom), 1'($urandom));
        repeat (150) @(posedge clk);
        #1 rst_n = 1'b0;
        q_a.delete();
        @(negedge clk);
        chk("rst_mid_txd", 32'(txd_a), 32'd1);
        chk("rst_mid_busy", 32'(busy_a), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(0, {$urandom, $urandom}, 4'($urandom_range(0, 11)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        end

        send(1, 64'hFF, 4'd1, 2'd2, 1'b0);
        wait_done(1, p37, "done_cycle_7bit_odd");
        for (int i = 0; i < 6; i++) begin
            send(1, {$urandom, $urandom}, 4'($urandom_range(0, 9)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        end

        w = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_a", 32'(q_a.size()), 32'd0);
        chk("drain_b", 32'(q_b.size()), 32'd0);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
